uart_rx_stream: RTL

- Serial receiver between the board RXD pin and the SoC's byte-wide receive path.
- Synchronises and oversamples the asynchronous line; frames 8N1 characters.
- Buffers received bytes in a small FIFO and presents them on a valid/ready stream to the SoC UART register block.
- Reports framing and overrun errors as single-cycle pulses.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 48 ++++
 rtl/uart_rx_stream.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, oversampling
// ratio and the baud divider calculation.
package uart_pkg;

  localparam int C_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rxState_e;

  // Integer division on purpose: the residual baud error is absorbed by mid-bit sampling.
  function automatic int calcDiv(input int clockFreq, input int baudRate);
    return clockFreq / (baudRate * C_OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; head_data is the oldest entry whenever empty=0.
// Also intended for reuse by the transmit path.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int C_DEPTH = 4,
  parameter int C_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic [C_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic               empty,
  output logic               full,
  output logic [C_WIDTH-1:0] head_data
);

  localparam int AW = $clog2(C_DEPTH);

  logic [AW:0]        wrPtr_q, rdPtr_q;
  logic [C_WIDTH-1:0] mem_q [C_DEPTH];
  logic               doPush, doPop;

  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // A push into a full FIFO is accepted only when the head is leaving in the same cycle.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  assign head_data = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      for (int i = 0; i < C_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q[AW-1:0]] <= push_data;
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver with FIFO and valid/ready output stream.
// Define UART_RX_PARITY_EN to receive one even-parity bit and add parity_err.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int C_CLOCKFREQ  = 12000000,
  parameter int C_BAUDRATE   = 9600,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  , output logic     parity_err
`endif
);

  localparam int C_DIV = calcDiv(C_CLOCKFREQ, C_BAUDRATE);
  localparam int CW    = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(C_DIV - 1);

  rxState_e    state_q, state_d;
  logic        rxdMeta_q, rxdSync_q, rxdPrev_q;
  logic [CW-1:0] tickCnt_q, tickCnt_d;
  logic [3:0]  sampleCnt_q, sampleCnt_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tick, midTick, fullTick;
  logic        pushReq, frameErr, popReq, fifoEmpty, fifoFull;
`ifdef UART_RX_PARITY_EN
  logic        parityBad_q, parityBad_d;
`endif

  assign tick     = (tickCnt_q == TICK_LAST);
  assign midTick  = tick && (sampleCnt_q == 4'd7);
  assign fullTick = tick && (sampleCnt_q == 4'd15);

  // Synchroniser idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxdMeta_q   <= 1'b1;
      rxdSync_q   <= 1'b1;
      rxdPrev_q   <= 1'b1;
      state_q     <= IDLE;
      tickCnt_q   <= '0;
      sampleCnt_q <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= 1'b0;
`endif
    end else begin
      rxdMeta_q   <= rxd;
      rxdSync_q   <= rxdMeta_q;
      rxdPrev_q   <= rxdSync_q;
      state_q     <= state_d;
      tickCnt_q   <= tickCnt_d;
      sampleCnt_q <= sampleCnt_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= parityBad_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    tickCnt_d   = tick ? '0 : tickCnt_q + 1'b1;
    sampleCnt_d = tick ? sampleCnt_q + 4'd1 : sampleCnt_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    pushReq     = 1'b0;
    frameErr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBad_d = parityBad_q;
`endif
    case (state_q)
      IDLE: begin
        // Restarting both counters here aligns every later sample to the start edge.
        if (rxdPrev_q && !rxdSync_q) begin
          state_d     = START;
          tickCnt_d   = '0;
          sampleCnt_d = '0;
        end
      end
      START: begin
        if (midTick) begin
          sampleCnt_d = '0;
          bitCnt_d    = '0;
          state_d     = rxdSync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (fullTick) begin
          shift_d  = {rxdSync_q, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (fullTick) begin
          parityBad_d = (^shift_q) ^ rxdSync_q;
          state_d     = STOP;
        end
      end
`endif
      STOP: begin
        if (fullTick) begin
          if (rxdSync_q) begin
            pushReq = 1'b1;
            state_d = IDLE;
          end else begin
            frameErr = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxdSync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .C_DEPTH(C_FIFO_DEPTH),
    .C_WIDTH(8)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (pushReq),
    .push_data(shift_q),
    .pop      (popReq),
    .empty    (fifoEmpty),
    .full     (fifoFull),
    .head_data(rx_data)
  );

  assign rx_valid  = !fifoEmpty;
  assign popReq    = rx_valid && rx_ready;
  assign frame_err = frameErr;
  assign overrun   = pushReq && fifoFull && !popReq;
`ifdef UART_RX_PARITY_EN
  assign parity_err = (state_q == STOP) && fullTick && parityBad_q;
`endif

endmodule
